// File: rtl/serial_fas.sv
// Bit-serial N-bit adder/subtractor: one full adder-subtractor slice plus a carry/borrow flop, LSB first.
// Optional signed-overflow output enabled by defining SERIAL_FAS_OVF_EN.
module serial_fas #(
  parameter int unsigned N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         a_ns,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
`ifdef SERIAL_FAS_OVF_EN
  output logic         ovf,
`endif
  output logic         busy,
  output logic         done,
  output logic [N-1:0] result,
  output logic         cout
);

  localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state, state_nx;
  logic [CW-1:0] cnt;
  logic [N-1:0]  a_sr, b_sr, acc, acc_nx;
  logic          mode, c;
  logic          ai, bi, s, c_nx, last;
  logic          load, busy_nx, done_nx;

  // Bit slice: mode=1 adds with carry, mode=0 subtracts with borrow
  assign ai     = a_sr[0];
  assign bi     = b_sr[0];
  assign s      = ai ^ bi ^ c;
  assign c_nx   = mode ? ((ai & bi) | (c & (ai ^ bi)))
                       : ((~ai & bi) | (~(ai ^ bi) & c));
  assign acc_nx = {s, acc[N-1:1]};
  assign last   = (state == RUN) && (cnt == CW'(N - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = RUN;
      RUN:     if (last)  state_nx = DONE;
      DONE:    state_nx = start ? RUN : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // A start is accepted from IDLE or DONE, never mid-operation
  always_comb begin
    load    = 1'b0;
    busy_nx = 1'b0;
    done_nx = 1'b0;
    load    = start && (state != RUN);
    busy_nx = (state_nx == RUN);
    done_nx = (state_nx == DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sr   <= '0;
      b_sr   <= '0;
      acc    <= '0;
      mode   <= 1'b0;
      c      <= 1'b0;
      cnt    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
      cout   <= 1'b0;
`ifdef SERIAL_FAS_OVF_EN
      ovf    <= 1'b0;
`endif
    end else begin
      busy <= busy_nx;
      done <= done_nx;
      if (load) begin
        a_sr <= a;
        b_sr <= b;
        mode <= a_ns;
        c    <= 1'b0;
        cnt  <= '0;
        acc  <= '0;
      end else if (state == RUN) begin
        a_sr <= {1'b0, a_sr[N-1:1]};
        b_sr <= {1'b0, b_sr[N-1:1]};
        acc  <= acc_nx;
        c    <= c_nx;
        cnt  <= last ? '0 : cnt + CW'(1);
        if (last) begin
          result <= acc_nx;
          cout   <= c_nx;
`ifdef SERIAL_FAS_OVF_EN
          ovf    <= c ^ c_nx;
`endif
        end
      end
    end
  end

endmodule

// File: tb/tb_serial_fas.sv
// Directed self-checking bench for serial_fas (N=8); ovf checks compile in with SERIAL_FAS_OVF_EN.
module tb_serial_fas;

  localparam int unsigned N = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         a_ns;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         busy;
  logic         done;
  logic [N-1:0] result;
  logic         cout;
`ifdef SERIAL_FAS_OVF_EN
  logic         ovf;
`endif

  int asserts  = 0;
  int failures = 0;

  serial_fas #(.N(N)) dut (
    .clk(clk), .rst(rst), .start(start), .a_ns(a_ns), .a(a), .b(b),
`ifdef SERIAL_FAS_OVF_EN
    .ovf(ovf),
`endif
    .busy(busy), .done(done), .result(result), .cout(cout)
  );

  always #5 clk = ~clk;

  // Drive one start pulse, then count edges until done (lat=-1 on timeout) and busy cycles.
  task automatic do_op(input logic m, input logic [N-1:0] x, input logic [N-1:0] y,
                       output int lat, output int busy_cyc);
    @(negedge clk);
    start = 1'b1; a_ns = m; a = x; b = y;
    @(negedge clk);
    start = 1'b0;
    lat = -1;
    busy_cyc = 0;
    for (int j = 0; j < 40; j++) begin
      if (done) begin
        lat = j;
        break;
      end
      if (busy) busy_cyc++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; a_ns = 1'b0; a = '0; b = '0;
    repeat (2) @(negedge clk);
    asserts++; if (busy !== 1'b0)   begin failures++; $display("FAIL reset_busy got %b want 0", busy); end
    asserts++; if (done !== 1'b0)   begin failures++; $display("FAIL reset_done got %b want 0", done); end
    asserts++; if (result !== 8'h00) begin failures++; $display("FAIL reset_result got %h want 00", result); end
    asserts++; if (cout !== 1'b0)   begin failures++; $display("FAIL reset_cout got %b want 0", cout); end
`ifdef SERIAL_FAS_OVF_EN
    asserts++; if (ovf !== 1'b0)    begin failures++; $display("FAIL reset_ovf got %b want 0", ovf); end
`endif
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_add();
    int lat, bc;
    do_op(1'b1, 8'h5A, 8'h3C, lat, bc);
    asserts++; if (lat !== 8)        begin failures++; $display("FAIL add1_latency got %0d want 8", lat); end
    asserts++; if (bc !== 8)         begin failures++; $display("FAIL add1_busy_cycles got %0d want 8", bc); end
    asserts++; if (result !== 8'h96) begin failures++; $display("FAIL add1_result got %h want 96", result); end
    asserts++; if (cout !== 1'b0)    begin failures++; $display("FAIL add1_cout got %b want 0", cout); end
    asserts++; if (busy !== 1'b0)    begin failures++; $display("FAIL add1_busy_at_done got %b want 0", busy); end
    @(negedge clk);
    asserts++; if (done !== 1'b0)    begin failures++; $display("FAIL add1_done_pulse got %b want 0", done); end
    asserts++; if (result !== 8'h96) begin failures++; $display("FAIL add1_hold got %h want 96", result); end

    do_op(1'b1, 8'hFF, 8'h01, lat, bc);
    asserts++; if (result !== 8'h00) begin failures++; $display("FAIL add2_result got %h want 00", result); end
    asserts++; if (cout !== 1'b1)    begin failures++; $display("FAIL add2_cout got %b want 1", cout); end
`ifdef SERIAL_FAS_OVF_EN
    asserts++; if (ovf !== 1'b0)     begin failures++; $display("FAIL add2_ovf got %b want 0", ovf); end
`endif

    do_op(1'b1, 8'h7F, 8'h01, lat, bc);
    asserts++; if (result !== 8'h80) begin failures++; $display("FAIL add3_result got %h want 80", result); end
    asserts++; if (cout !== 1'b0)    begin failures++; $display("FAIL add3_cout got %b want 0", cout); end
`ifdef SERIAL_FAS_OVF_EN
    asserts++; if (ovf !== 1'b1)     begin failures++; $display("FAIL add3_ovf got %b want 1", ovf); end
`endif
  endtask

  task automatic test_sub();
    int lat, bc;
    do_op(1'b0, 8'h10, 8'h01, lat, bc);
    asserts++; if (lat !== 8)        begin failures++; $display("FAIL sub1_latency got %0d want 8", lat); end
    asserts++; if (result !== 8'h0F) begin failures++; $display("FAIL sub1_result got %h want 0f", result); end
    asserts++; if (cout !== 1'b0)    begin failures++; $display("FAIL sub1_borrow got %b want 0", cout); end
`ifdef SERIAL_FAS_OVF_EN
    asserts++; if (ovf !== 1'b0)     begin failures++; $display("FAIL sub1_ovf got %b want 0", ovf); end
`endif

    do_op(1'b0, 8'h01, 8'h02, lat, bc);
    asserts++; if (result !== 8'hFF) begin failures++; $display("FAIL sub2_result got %h want ff", result); end
    asserts++; if (cout !== 1'b1)    begin failures++; $display("FAIL sub2_borrow got %b want 1", cout); end

    do_op(1'b0, 8'h80, 8'h01, lat, bc);
    asserts++; if (result !== 8'h7F) begin failures++; $display("FAIL sub3_result got %h want 7f", result); end
    asserts++; if (cout !== 1'b0)    begin failures++; $display("FAIL sub3_borrow got %b want 0", cout); end
`ifdef SERIAL_FAS_OVF_EN
    asserts++; if (ovf !== 1'b1)     begin failures++; $display("FAIL sub3_ovf got %b want 1", ovf); end
`endif
  endtask

  task automatic test_ignore_start();
    int ndone, lat;
    @(negedge clk);
    start = 1'b1; a_ns = 1'b1; a = 8'h12; b = 8'h34;
    @(negedge clk);
    start = 1'b0;
    ndone = 0; lat = -1;
    for (int j = 0; j < 20; j++) begin
      if (j == 3) begin
        start = 1'b1; a_ns = 1'b0; a = 8'hFF; b = 8'hEE;
      end else if (j == 4) begin
        start = 1'b0;
      end
      if (done) begin
        ndone++;
        if (lat < 0) lat = j;
        asserts++; if (result !== 8'h46) begin failures++; $display("FAIL ignore_result got %h want 46", result); end
        asserts++; if (cout !== 1'b0)    begin failures++; $display("FAIL ignore_cout got %b want 0", cout); end
      end
      @(negedge clk);
    end
    asserts++; if (ndone !== 1) begin failures++; $display("FAIL ignore_done_count got %0d want 1", ndone); end
    asserts++; if (lat !== 8)   begin failures++; $display("FAIL ignore_latency got %0d want 8", lat); end
  endtask

  task automatic test_back_to_back();
    int lat, bc;
    do_op(1'b1, 8'h20, 8'h05, lat, bc);
    asserts++; if (result !== 8'h25) begin failures++; $display("FAIL b2b_first_result got %h want 25", result); end
    // Still in DONE here: this start is sampled on the next edge
    start = 1'b1; a_ns = 1'b1; a = 8'h01; b = 8'h01;
    @(negedge clk);
    start = 1'b0;
    asserts++; if (busy !== 1'b1) begin failures++; $display("FAIL b2b_busy_after_accept got %b want 1", busy); end
    lat = -1;
    for (int j = 0; j < 40; j++) begin
      if (done) begin
        lat = j;
        break;
      end
      @(negedge clk);
    end
    asserts++; if (lat !== 8)        begin failures++; $display("FAIL b2b_second_latency got %0d want 8", lat); end
    asserts++; if (result !== 8'h02) begin failures++; $display("FAIL b2b_second_result got %h want 02", result); end
  endtask

  task automatic test_reset_mid();
    int ndone, lat, bc;
    @(negedge clk);
    start = 1'b1; a_ns = 1'b1; a = 8'h55; b = 8'h11;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    #1;
    asserts++; if (busy !== 1'b0)    begin failures++; $display("FAIL rstmid_busy got %b want 0", busy); end
    asserts++; if (result !== 8'h00) begin failures++; $display("FAIL rstmid_result got %h want 00", result); end
    asserts++; if (cout !== 1'b0)    begin failures++; $display("FAIL rstmid_cout got %b want 0", cout); end
    @(negedge clk);
    rst = 1'b0;
    ndone = 0;
    for (int j = 0; j < 12; j++) begin
      if (done) ndone++;
      @(negedge clk);
    end
    asserts++; if (ndone !== 0) begin failures++; $display("FAIL rstmid_no_done got %0d want 0", ndone); end
    do_op(1'b1, 8'h03, 8'h04, lat, bc);
    asserts++; if (lat !== 8)        begin failures++; $display("FAIL rstmid_next_latency got %0d want 8", lat); end
    asserts++; if (result !== 8'h07) begin failures++; $display("FAIL rstmid_next_result got %h want 07", result); end
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, failures);
    $finish;
  end

endmodule
